// File: rtl/ysyx_23060180_lsu.sv
// Load/store unit: one memory access at a time, IDLE -> ACCESS -> DONE.
// Optional access watchdog enabled by YSYX_23060180_LSU_TIMEOUT_EN.
module ysyx_23060180_lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [2:0]  req_func3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        err_align,
    output logic        bus_err
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t      state, next;
    logic        wen_q, err_q, req_bad, timeout_hit, to_flag;
    logic [2:0]  func3_q;
    logic [31:0] addr_q, wdata_q, rdata_q, st_data, load_val;
    logic [4:0]  rd_q;
    logic [3:0]  lane_mask;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Illegal funct3 and misalignment are both reported through err_align.
    always_comb begin
        case (req_func3)
            3'b000, 3'b100: req_bad = 1'b0;
            3'b001, 3'b101: req_bad = req_addr[0];
            3'b010:         req_bad = (req_addr[1:0] != 2'b00);
            default:        req_bad = 1'b1;
        endcase
    end

`ifdef YSYX_23060180_LSU_TIMEOUT_EN
    logic [7:0] cnt_q;
    logic       to_q;
    // Loaded with 254 so the terminal count is reached in the 255th ACCESS cycle.
    assign timeout_hit = (cnt_q == 8'd0);
    assign to_flag     = to_q;
    assign bus_err     = (state == DONE) && to_q;
`else
    assign timeout_hit = 1'b0;
    assign to_flag     = 1'b0;
    assign bus_err     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wen_q   <= 1'b0;
            err_q   <= 1'b0;
            func3_q <= 3'b000;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rd_q    <= 5'd0;
            rdata_q <= 32'h0;
`ifdef YSYX_23060180_LSU_TIMEOUT_EN
            cnt_q   <= 8'd0;
            to_q    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    wen_q   <= req_wen;
                    err_q   <= req_bad;
                    func3_q <= req_func3;
                    addr_q  <= req_addr;
                    wdata_q <= req_wdata;
                    rd_q    <= req_rd;
`ifdef YSYX_23060180_LSU_TIMEOUT_EN
                    cnt_q   <= 8'd254;
                    to_q    <= 1'b0;
`endif
                end
                ACCESS: begin
                    if (mem_ack) begin
                        if (!wen_q) rdata_q <= mem_rdata;
                    end
`ifdef YSYX_23060180_LSU_TIMEOUT_EN
                    else if (timeout_hit) to_q <= 1'b1;
                    else                  cnt_q <= cnt_q - 8'd1;
`endif
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        case (func3_q[1:0])
            2'b00: begin
                lane_mask = 4'b0001 << addr_q[1:0];
                st_data   = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                lane_mask = 4'b0011 << {addr_q[1], 1'b0};
                st_data   = {2{wdata_q[15:0]}};
            end
            default: begin
                lane_mask = 4'b1111;
                st_data   = wdata_q;
            end
        endcase
    end

    always_comb begin
        case (addr_q[1:0])
            2'b00:   byte_sel = rdata_q[7:0];
            2'b01:   byte_sel = rdata_q[15:8];
            2'b10:   byte_sel = rdata_q[23:16];
            default: byte_sel = rdata_q[31:24];
        endcase
        half_sel = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];
        case (func3_q)
            3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_val = {24'h0, byte_sel};
            3'b101:  load_val = {16'h0, half_sel};
            default: load_val = rdata_q;
        endcase
    end

    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_wdata = st_data;

    always_comb begin
        next      = state;
        req_ready = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_wmask = 4'b0000;
        wb_valid  = 1'b0;
        wb_rd     = 5'd0;
        wb_data   = 32'h0;
        err_align = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) next = req_bad ? DONE : ACCESS;
            end
            ACCESS: begin
                mem_rd    = !wen_q;
                mem_wr    = wen_q;
                mem_wmask = wen_q ? lane_mask : 4'b0000;
                if (mem_ack || timeout_hit) next = DONE;
            end
            DONE: begin
                next = IDLE;
                if (err_q) begin
                    err_align = 1'b1;
                end else if (!to_flag) begin
                    wb_valid = 1'b1;
                    wb_rd    = wen_q ? 5'd0 : rd_q;
                    wb_data  = wen_q ? 32'h0 : load_val;
                end
            end
            default: next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ysyx_23060180_lsu.sv
// Directed vector bench for ysyx_23060180_lsu; timeout sequence runs only
// when YSYX_23060180_LSU_TIMEOUT_EN is defined.
module tb_ysyx_23060180_lsu;

    logic        clk = 1'b0;
    logic        rst, req_valid, req_ready, req_wen;
    logic [2:0]  req_func3;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        mem_rd, mem_wr;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;
    logic        mem_ack, wb_valid, err_align, bus_err;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ysyx_23060180_lsu dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_wen(req_wen), .req_func3(req_func3), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rd(req_rd), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .wb_valid(wb_valid),
        .wb_rd(wb_rd), .wb_data(wb_data), .err_align(err_align), .bus_err(bus_err)
    );

    typedef struct {
        logic        wen;
        logic [2:0]  func3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [31:0] rdata;
        int          delay;
        logic        err;
        logic [3:0]  wmask;
        logic [31:0] mwdata;
        logic        wbv;
        logic [4:0]  wbrd;
        logic [31:0] wbdata;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive_req(input vec_t v);
        req_valid = 1'b1;
        req_wen   = v.wen;
        req_func3 = v.func3;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_rd    = v.rd;
    endtask

    task automatic run_vec(input int i, input vec_t v);
        @(negedge clk);
        chk($sformatf("v%0d ready_before", i), req_ready, 1);
        drive_req(v);
        @(negedge clk);
        req_valid = 1'b0;
        if (v.err) begin
            chk($sformatf("v%0d err_memrd", i), mem_rd, 0);
            chk($sformatf("v%0d err_memwr", i), mem_wr, 0);
            chk($sformatf("v%0d err_align", i), err_align, 1);
            chk($sformatf("v%0d err_wbv", i), wb_valid, 0);
            chk($sformatf("v%0d err_ready", i), req_ready, 0);
        end else begin
            for (int k = 0; k <= v.delay; k++) begin
                chk($sformatf("v%0d c%0d mem_rd", i, k), mem_rd, !v.wen);
                chk($sformatf("v%0d c%0d mem_wr", i, k), mem_wr, v.wen);
                chk($sformatf("v%0d c%0d addr", i, k), mem_addr, {v.addr[31:2], 2'b00});
                chk($sformatf("v%0d c%0d wmask", i, k), mem_wmask, v.wmask);
                if (v.wen) chk($sformatf("v%0d c%0d wdata", i, k), mem_wdata, v.mwdata);
                chk($sformatf("v%0d c%0d wbv", i, k), wb_valid, 0);
                mem_ack   = (k == v.delay);
                mem_rdata = (k == v.delay) ? v.rdata : 32'hDEAD_BEEF;
                @(negedge clk);
            end
            mem_ack = 1'b0;
            chk($sformatf("v%0d done_memrd", i), mem_rd, 0);
            chk($sformatf("v%0d wb_valid", i), wb_valid, v.wbv);
            chk($sformatf("v%0d wb_rd", i), wb_rd, v.wbrd);
            chk($sformatf("v%0d wb_data", i), wb_data, v.wbdata);
            chk($sformatf("v%0d done_err", i), err_align, 0);
        end
        @(negedge clk);
        chk($sformatf("v%0d ready_after", i), req_ready, 1);
        chk($sformatf("v%0d wbv_after", i), wb_valid, 0);
        chk($sformatf("v%0d erra_after", i), err_align, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b0, 3'b000, 32'h8000_0003, 32'h0,         5'd5,  32'h80FF_1234, 0, 1'b0, 4'h0, 32'h0,         1'b1, 5'd5,  32'hFFFF_FF80};
        vecs[1]  = '{1'b1, 3'b001, 32'h8000_0102, 32'h0000_BEEF, 5'd7,  32'h0,         0, 1'b0, 4'hC, 32'hBEEF_BEEF, 1'b1, 5'd0,  32'h0};
        vecs[2]  = '{1'b0, 3'b010, 32'h8000_0006, 32'h0,         5'd8,  32'h0,         0, 1'b1, 4'h0, 32'h0,         1'b0, 5'd0,  32'h0};
        vecs[3]  = '{1'b0, 3'b101, 32'h8000_0010, 32'h0,         5'd9,  32'h0000_F00D, 5, 1'b0, 4'h0, 32'h0,         1'b1, 5'd9,  32'h0000_F00D};
        vecs[4]  = '{1'b0, 3'b100, 32'h8000_0001, 32'h0,         5'd3,  32'h1234_A5C3, 1, 1'b0, 4'h0, 32'h0,         1'b1, 5'd3,  32'h0000_00A5};
        vecs[5]  = '{1'b0, 3'b001, 32'h8000_0002, 32'h0,         5'd4,  32'h8001_7FFF, 2, 1'b0, 4'h0, 32'h0,         1'b1, 5'd4,  32'hFFFF_8001};
        vecs[6]  = '{1'b0, 3'b010, 32'h8000_0008, 32'h0,         5'd31, 32'h1234_5678, 0, 1'b0, 4'h0, 32'h0,         1'b1, 5'd31, 32'h1234_5678};
        vecs[7]  = '{1'b1, 3'b000, 32'h8000_0001, 32'hAABB_CC5A, 5'd2,  32'h0,         1, 1'b0, 4'h2, 32'h5A5A_5A5A, 1'b1, 5'd0,  32'h0};
        vecs[8]  = '{1'b1, 3'b010, 32'h8000_000C, 32'hCAFE_F00D, 5'd1,  32'h0,         0, 1'b0, 4'hF, 32'hCAFE_F00D, 1'b1, 5'd0,  32'h0};
        vecs[9]  = '{1'b1, 3'b001, 32'h8000_0001, 32'h1234_5678, 5'd1,  32'h0,         0, 1'b1, 4'h0, 32'h0,         1'b0, 5'd0,  32'h0};
        vecs[10] = '{1'b0, 3'b011, 32'h8000_0000, 32'h0,         5'd6,  32'h0,         0, 1'b1, 4'h0, 32'h0,         1'b0, 5'd0,  32'h0};
        vecs[11] = '{1'b1, 3'b000, 32'h8000_0003, 32'h0000_0011, 5'd1,  32'h0,         0, 1'b0, 4'h8, 32'h1111_1111, 1'b1, 5'd0,  32'h0};
        vecs[12] = '{1'b0, 3'b000, 32'h8000_0000, 32'h0,         5'd10, 32'h0000_007F, 0, 1'b0, 4'h0, 32'h0,         1'b1, 5'd10, 32'h0000_007F};
        vecs[13] = '{1'b0, 3'b001, 32'h8000_0000, 32'h0,         5'd11, 32'h0000_8000, 3, 1'b0, 4'h0, 32'h0,         1'b1, 5'd11, 32'hFFFF_8000};

        rst = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_func3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0;
        mem_rdata = 32'h0; mem_ack = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("rst ready", req_ready, 1);
        chk("rst mem_rd", mem_rd, 0);
        chk("rst mem_wr", mem_wr, 0);
        chk("rst mem_addr", mem_addr, 0);
        chk("rst mem_wdata", mem_wdata, 0);
        chk("rst mem_wmask", mem_wmask, 0);
        chk("rst wb_valid", wb_valid, 0);
        chk("rst wb_rd", wb_rd, 0);
        chk("rst wb_data", wb_data, 0);
        chk("rst err_align", err_align, 0);
        chk("rst bus_err", bus_err, 0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

        // Stray ack while idle must not produce a writeback.
        @(negedge clk);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("idle_ack wbv", wb_valid, 0);
        chk("idle_ack ready", req_ready, 1);

        // Reset in the middle of an access abandons it; late ack is ignored.
        drive_req(vecs[0]);
        @(negedge clk);
        req_valid = 1'b0;
        chk("mid_rst in_access", mem_rd, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst ready", req_ready, 1);
        chk("mid_rst mem_rd", mem_rd, 0);
        chk("mid_rst addr", mem_addr, 0);
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("late_ack wbv", wb_valid, 0);
        chk("late_ack ready", req_ready, 1);
        @(negedge clk);
        chk("late_ack wbv2", wb_valid, 0);

        // Reset wins over a simultaneous request.
        drive_req(vecs[6]);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; req_valid = 1'b0;
        chk("rst_prio ready", req_ready, 1);
        chk("rst_prio mem_rd", mem_rd, 0);
        @(negedge clk);
        chk("rst_prio ready2", req_ready, 1);

`ifdef YSYX_23060180_LSU_TIMEOUT_EN
        begin
            int cycles = 0;
            drive_req(vecs[6]);
            @(negedge clk);
            req_valid = 1'b0;
            while (mem_rd && cycles < 400) begin
                cycles++;
                @(negedge clk);
            end
            chk("to cycles", cycles, 255);
            chk("to bus_err", bus_err, 1);
            chk("to wbv", wb_valid, 0);
            chk("to erra", err_align, 0);
            @(negedge clk);
            chk("to bus_err_clr", bus_err, 0);
            chk("to ready", req_ready, 1);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
